// File: rtl/exanet_pkg.sv
// rtl/exanet_pkg.sv - exanet flit tags, producer state encoding and flit builder
// Shared by traffic producers and pattern-checking consumers.
//   EXA_TAG_HDR/PLD/FTR : tag byte in data[127:120]
//   exa_state_e         : producer FSM states
//   exa_flit()          : {tag, vc, seq, index, 88'h0}; a header uses index 0
package exanet_pkg;

    localparam logic [7:0] EXA_TAG_HDR = 8'hE0;
    localparam logic [7:0] EXA_TAG_PLD = 8'hD0;
    localparam logic [7:0] EXA_TAG_FTR = 8'hF0;

    typedef enum logic [2:0] {
        EXA_ST_IDLE    = 3'd0,
        EXA_ST_HEADER  = 3'd1,
        EXA_ST_PAYLOAD = 3'd2,
        EXA_ST_FOOTER  = 3'd3,
        EXA_ST_GAP     = 3'd4
    } exa_state_e;

    function automatic logic [127:0] exa_flit(
        input logic [7:0]  tag,
        input logic [7:0]  vc,
        input logic [15:0] seq,
        input logic [7:0]  idx
    );
        return {tag, vc, seq, idx, 88'h0};
    endfunction

endpackage

// File: rtl/exanet_if.sv
// rtl/exanet_if.sv - exanet three-phase flit link (header / payload / footer)
// Signals:
//   header_valid/ready, payload_valid/ready, footer_valid/ready : per-phase handshake
//   data[127:0]                                                 : flit contents
// master drives valids and data, slave drives readies.
interface exanet;

    logic         header_valid;
    logic         header_ready;
    logic         payload_valid;
    logic         payload_ready;
    logic         footer_valid;
    logic         footer_ready;
    logic [127:0] data;

    modport master (
        output header_valid, payload_valid, footer_valid, data,
        input  header_ready, payload_ready, footer_ready
    );

    modport slave (
        input  header_valid, payload_valid, footer_valid, data,
        output header_ready, payload_ready, footer_ready
    );

endinterface

// File: rtl/exa_rr_vc_arbiter.sv
// rtl/exa_rr_vc_arbiter.sv - combinational round-robin channel picker
// Ports:
//   mask_i        in  N  : eligible channels
//   last_i        in  VW : channel served last; search starts just after it
//   grant_o       out VW : first eligible channel after last_i, wrapping N-1 -> 0
//   grant_valid_o out 1  : some channel is eligible
module exa_rr_vc_arbiter #(
    parameter  int N  = 4,
    localparam int VW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask_i,
    input  logic [VW-1:0] last_i,
    output logic [VW-1:0] grant_o,
    output logic          grant_valid_o
);

    logic [VW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest eligible channel
    // after last_i is the one left in grant_o. Offset N is last_i itself,
    // which is only chosen when it is the sole eligible channel.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        for (int i = N; i >= 1; i--) begin
            idx = VW'((int'(last_i) + i) % N);
            if (mask_i[idx]) begin
                grant_o       = idx;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exa_traffic_producer_with_vcs.sv
// rtl/exa_traffic_producer_with_vcs.sv - exanet packet source over round-robin virtual channels
// Ports:
//   clk, resetn (async, active-low)
//   i_enable     : permit starting new packets
//   i_vc_mask[N] : eligible channels, sampled only when idle
//   i_gap[4]     : idle cycles after each footer handshake
//   exa          : exanet master (header, PAYLOAD_FLITS payloads, footer)
//   o_vc         : channel of the packet in flight
//   o_busy       : header valid through footer handshake
//   o_pkt_total  : completed packets, wraps
module exa_traffic_producer_with_vcs
    import exanet_pkg::*;
#(
    parameter  int prio_num      = 2,
    parameter  int vc_num        = 2,
    parameter  int PAYLOAD_FLITS = 16,
    localparam int N             = vc_num * prio_num,
    localparam int VW            = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_enable,
    input  logic [N-1:0]  i_vc_mask,
    input  logic [3:0]    i_gap,
    exanet.master         exa,
    output logic [VW-1:0] o_vc,
    output logic          o_busy,
    output logic [31:0]   o_pkt_total
);

    localparam int         KW      = $clog2(PAYLOAD_FLITS + 1);
    localparam logic [7:0] FTR_IDX = 8'(PAYLOAD_FLITS + 1);

    exa_state_e     state_q, state_d;
    logic [VW-1:0]  vc_q, vc_d;
    logic [VW-1:0]  last_vc_q, last_vc_d;
    logic [KW-1:0]  k_q, k_d;
    logic [3:0]     gap_q, gap_d;
    logic [127:0]   data_q, data_d;
    logic [31:0]    total_q, total_d;
    logic [15:0]    seq_q [N];
    logic           seq_inc;

    logic [VW-1:0]  grant;
    logic           grant_valid;
    logic [7:0]     vc8;
    logic [15:0]    seq_cur;

    exa_rr_vc_arbiter #(.N(N)) u_arb (
        .mask_i        (i_vc_mask),
        .last_i        (last_vc_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // seq of the channel in flight cannot change until its footer handshake,
    // so every flit of a packet carries the same seq.
    assign vc8     = 8'(vc_q);
    assign seq_cur = seq_q[vc_q];

    always_comb begin
        state_d   = state_q;
        vc_d      = vc_q;
        last_vc_d = last_vc_q;
        k_d       = k_q;
        gap_d     = gap_q;
        data_d    = data_q;
        total_d   = total_q;
        seq_inc   = 1'b0;
        case (state_q)
            EXA_ST_IDLE: begin
                if (i_enable && grant_valid) begin
                    state_d = EXA_ST_HEADER;
                    vc_d    = grant;
                    data_d  = exa_flit(EXA_TAG_HDR, 8'(grant), seq_q[grant], 8'h00);
                end
            end
            EXA_ST_HEADER: begin
                if (exa.header_ready) begin
                    state_d = EXA_ST_PAYLOAD;
                    k_d     = KW'(1);
                    data_d  = exa_flit(EXA_TAG_PLD, vc8, seq_cur, 8'h01);
                end
            end
            EXA_ST_PAYLOAD: begin
                if (exa.payload_ready) begin
                    if (k_q == KW'(PAYLOAD_FLITS)) begin
                        state_d = EXA_ST_FOOTER;
                        data_d  = exa_flit(EXA_TAG_FTR, vc8, seq_cur, FTR_IDX);
                    end else begin
                        k_d    = k_q + KW'(1);
                        data_d = exa_flit(EXA_TAG_PLD, vc8, seq_cur, 8'(k_q + KW'(1)));
                    end
                end
            end
            EXA_ST_FOOTER: begin
                if (exa.footer_ready) begin
                    seq_inc   = 1'b1;
                    total_d   = total_q + 32'd1;
                    last_vc_d = vc_q;
                    data_d    = '0;
                    gap_d     = i_gap;
                    state_d   = (i_gap != 4'd0) ? EXA_ST_GAP : EXA_ST_IDLE;
                end
            end
            EXA_ST_GAP: begin
                // gap_q holds the remaining GAP cycles including this one.
                if (gap_q <= 4'd1) begin
                    state_d = EXA_ST_IDLE;
                    gap_d   = 4'd0;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = EXA_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= EXA_ST_IDLE;
            vc_q      <= '0;
            last_vc_q <= VW'(N - 1);
            k_q       <= '0;
            gap_q     <= '0;
            data_q    <= '0;
            total_q   <= '0;
            for (int v = 0; v < N; v++) begin
                seq_q[v] <= '0;
            end
        end else begin
            state_q   <= state_d;
            vc_q      <= vc_d;
            last_vc_q <= last_vc_d;
            k_q       <= k_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            total_q   <= total_d;
            for (int v = 0; v < N; v++) begin
                if (seq_inc && (vc_q == VW'(v))) begin
                    seq_q[v] <= seq_q[v] + 16'd1;
                end
            end
        end
    end

    assign exa.header_valid  = (state_q == EXA_ST_HEADER);
    assign exa.payload_valid = (state_q == EXA_ST_PAYLOAD);
    assign exa.footer_valid  = (state_q == EXA_ST_FOOTER);
    assign exa.data          = data_q;

    assign o_vc        = vc_q;
    assign o_busy      = (state_q == EXA_ST_HEADER) || (state_q == EXA_ST_PAYLOAD) ||
                         (state_q == EXA_ST_FOOTER);
    assign o_pkt_total = total_q;

endmodule

// File: tb/tb_exa_traffic_producer_with_vcs.sv
// tb/tb_exa_traffic_producer_with_vcs.sv - scoreboard bench for exa_traffic_producer_with_vcs
module tb_exa_traffic_producer_with_vcs;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_enable = 1'b0;
    logic [3:0]  i_vc_mask = 4'h0;
    logic [3:0]  i_gap = 4'h0;
    logic [1:0]  o_vc;
    logic        o_busy;
    logic [31:0] o_pkt_total;

    exanet exa ();

    exa_traffic_producer_with_vcs #(
        .prio_num      (2),
        .vc_num        (2),
        .PAYLOAD_FLITS (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_enable    (i_enable),
        .i_vc_mask   (i_vc_mask),
        .i_gap       (i_gap),
        .exa         (exa),
        .o_vc        (o_vc),
        .o_busy      (o_busy),
        .o_pkt_total (o_pkt_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   kind;   // 0 header, 1 payload, 2 footer
        logic [1:0]   vc;
        logic [127:0] data;
    } exp_t;

    exp_t        sb [$];
    int          hdr_cyc [$];
    int          ftr_cyc [$];
    logic [15:0] exp_seq [4];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hdr_count = 0;
    int          pld_k = 0;
    logic        bp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_pkt(input logic [1:0] vc);
        exp_t        e;
        logic [15:0] s;
        s = exp_seq[vc];
        e.vc = vc;
        e.kind = 2'd0;
        e.data = {8'hE0, 6'h0, vc, s, 96'h0};
        sb.push_back(e);
        for (int k = 1; k <= 16; k++) begin
            e.kind = 2'd1;
            e.data = {8'hD0, 6'h0, vc, s, 8'(k), 88'h0};
            sb.push_back(e);
        end
        e.kind = 2'd2;
        e.data = {8'hF0, 6'h0, vc, s, 8'd17, 88'h0};
        sb.push_back(e);
        exp_seq[vc] = s + 16'd1;
    endtask

    // Readies: all high, or random when backpressure is on.
    initial begin
        exa.header_ready  = 1'b1;
        exa.payload_ready = 1'b1;
        exa.footer_ready  = 1'b1;
    end
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            exa.header_ready  = 1'($urandom_range(0, 1));
            exa.payload_ready = 1'($urandom_range(0, 1));
            exa.footer_ready  = 1'($urandom_range(0, 1));
        end else begin
            exa.header_ready  = 1'b1;
            exa.payload_ready = 1'b1;
            exa.footer_ready  = 1'b1;
        end
    end

    // Monitor: sampled mid-cycle; a flit is consumed at the next rising edge.
    logic         prev_pending = 1'b0;
    logic [2:0]   prev_valids;
    logic [127:0] prev_data;
    always @(negedge clk) begin
        logic [2:0] v;
        logic       hs;
        logic [1:0] kind;
        exp_t       e;
        v = {exa.footer_valid, exa.payload_valid, exa.header_valid};
        if (!resetn) begin
            prev_pending = 1'b0;
        end else begin
            if (v != 3'b000) chk("valid_onehot", 128'($onehot(v)), 128'd1);
            if (prev_pending) begin
                chk("hold_valids", 128'(v), 128'(prev_valids));
                chk("hold_data", exa.data, prev_data);
            end
            hs = (exa.header_valid && exa.header_ready) ||
                 (exa.payload_valid && exa.payload_ready) ||
                 (exa.footer_valid && exa.footer_ready);
            if (hs) begin
                kind = exa.header_valid ? 2'd0 : (exa.payload_valid ? 2'd1 : 2'd2);
                if (sb.size() == 0) begin
                    chk("unexpected_flit", exa.data, 128'h0 - 128'h1);
                end else begin
                    e = sb.pop_front();
                    chk("flit_kind", 128'(kind), 128'(e.kind));
                    chk("flit_data", exa.data, e.data);
                    if (kind == 2'd0) begin
                        chk("o_vc", 128'(o_vc), 128'(e.vc));
                        hdr_cyc.push_back(cyc);
                        hdr_count++;
                    end else if (kind == 2'd1) begin
                        pld_k = int'(e.data[95:88]);
                    end else begin
                        ftr_cyc.push_back(cyc);
                    end
                end
            end
            prev_pending = (v != 3'b000) && !hs;
            prev_valids  = v;
            prev_data    = exa.data;
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        i_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", 128'({exa.footer_valid, exa.payload_valid, exa.header_valid}), 128'd0);
        chk("rst_data", exa.data, 128'd0);
        chk("rst_o_vc", 128'(o_vc), 128'd0);
        chk("rst_o_busy", 128'(o_busy), 128'd0);
        chk("rst_o_pkt_total", 128'(o_pkt_total), 128'd0);
        sb.delete();
        for (int i = 0; i < 4; i++) exp_seq[i] = 16'h0;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || o_busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 128'(n < 3000), 128'd1);
    endtask

    // Enable until n more headers have been accepted, then let the last packet finish.
    task automatic run_pkts(input int n);
        int start = hdr_count;
        int w = 0;
        i_enable = 1'b1;
        while (hdr_count < start + n && w < 5000) begin
            @(posedge clk);
            #1;
            w++;
        end
        i_enable = 1'b0;
        chk("hdr_timeout", 128'(w < 5000), 128'd1);
        drain();
    endtask

    task automatic wait_pld_k(input int k);
        int w = 0;
        pld_k = 0;
        while (pld_k < k && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("pld_k_timeout", 128'(w < 200), 128'd1);
    endtask

    initial begin
        int e;
        int stray;

        // Single channel, back-to-back, exact latency.
        do_reset();
        i_vc_mask = 4'b0001;
        i_gap = 4'd0;
        push_pkt(2'd0);
        push_pkt(2'd0);
        hdr_cyc.delete();
        ftr_cyc.delete();
        e = cyc;
        run_pkts(2);
        if (hdr_cyc.size() >= 2 && ftr_cyc.size() >= 1) begin
            chk("hdr_latency", 128'(hdr_cyc[0] - e), 128'd1);
            chk("pkt_cycles", 128'(ftr_cyc[0] - hdr_cyc[0] + 1), 128'd18);
            chk("b2b_gap", 128'(hdr_cyc[1] - ftr_cyc[0]), 128'd2);
        end else begin
            chk("timing_events", 128'(hdr_cyc.size()), 128'd2);
        end
        chk("total_t1", 128'(o_pkt_total), 128'd2);

        // All channels: round robin 0,1,2,3,0,1,2,3.
        do_reset();
        i_vc_mask = 4'b1111;
        for (int i = 0; i < 8; i++) push_pkt(2'(i));
        run_pkts(8);
        chk("total_t2", 128'(o_pkt_total), 128'd8);

        // Backpressure; every channel now carries seq 2.
        bp_en = 1'b1;
        for (int i = 0; i < 4; i++) push_pkt(2'(i));
        run_pkts(4);
        bp_en = 1'b0;
        chk("total_t3", 128'(o_pkt_total), 128'd12);

        // Enable dropped mid-payload, then idle checks.
        do_reset();
        i_vc_mask = 4'b0001;
        push_pkt(2'd0);
        i_enable = 1'b1;
        wait_pld_k(5);
        i_enable = 1'b0;
        drain();
        stray = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (exa.header_valid || exa.payload_valid || exa.footer_valid || o_busy) stray++;
        end
        chk("idle_after_disable", 128'(stray), 128'd0);
        i_vc_mask = 4'b0000;
        i_enable = 1'b1;
        stray = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (exa.header_valid || exa.payload_valid || exa.footer_valid || o_busy) stray++;
        end
        i_enable = 1'b0;
        chk("idle_mask_zero", 128'(stray), 128'd0);
        chk("total_t4", 128'(o_pkt_total), 128'd1);

        // Gap of 3 cycles on channel 1.
        i_vc_mask = 4'b0010;
        i_gap = 4'd3;
        push_pkt(2'd1);
        push_pkt(2'd1);
        hdr_cyc.delete();
        ftr_cyc.delete();
        run_pkts(2);
        i_gap = 4'd0;
        if (hdr_cyc.size() >= 2 && ftr_cyc.size() >= 1)
            chk("gap3_spacing", 128'(hdr_cyc[1] - ftr_cyc[0]), 128'd5);
        else
            chk("gap3_events", 128'(hdr_cyc.size()), 128'd2);

        // Reset during payload aborts; restart is a fresh header, seq 0, channel 0.
        i_vc_mask = 4'b0001;
        push_pkt(2'd0);
        i_enable = 1'b1;
        wait_pld_k(3);
        resetn = 1'b0;
        #1;
        chk("abort_valids", 128'({exa.footer_valid, exa.payload_valid, exa.header_valid}), 128'd0);
        chk("abort_busy", 128'(o_busy), 128'd0);
        i_enable = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) exp_seq[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        push_pkt(2'd0);
        run_pkts(1);
        chk("total_t6", 128'(o_pkt_total), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/exa_traffic_producer_with_vcs.md
# exa_traffic_producer_with_vcs

Synthesizable exanet packet source, the transmit end of the s2e virtual-channel test path. Emits fixed-length packets (header, 16 payload flits, footer) on an `exanet.master` port and selects among `vc_num*prio_num` virtual channels round-robin. Every flit carries a deterministic pattern (VC, per-VC sequence number, flit index), so a consumer checks traffic without hierarchical references into the generator.

## Interface
- `prio_num`, 2, number of priority levels
- `vc_num`, 2, virtual channels per priority; `N = vc_num*prio_num` total channels, `VW = $clog2(N)`
- `PAYLOAD_FLITS`, 16, payload flits per packet (must be ≥1)
- `clk` in 1: single clock
- `resetn` in 1: reset, asynchronous and active-low
- `i_enable` in 1: permit starting new packets
- `i_vc_mask` in N: bit v=1 makes channel v eligible
- `i_gap` in 4: idle cycles inserted after each footer handshake
- `exa` exanet.master: drives `header_valid`, `payload_valid`, `footer_valid`, `data[127:0]`; samples `header_ready`, `payload_ready`, `footer_ready`
- `o_vc` out VW: channel of the packet in flight
- `o_busy` out 1: high from header valid through footer handshake
- `o_pkt_total` out 32: packets completed (footer handshakes), wraps

## Operation
- States: IDLE, HEADER, PAYLOAD, FOOTER, GAP.
- IDLE: if `i_enable` and `i_vc_mask != 0`, pick the next eligible channel after `last_vc` (round-robin, wrapping N-1→0) and go to HEADER. Otherwise stay.
- HEADER: `header_valid=1`. On `header_ready`, go to PAYLOAD with flit index k=1.
- PAYLOAD: `payload_valid=1`. Each handshake increments k. The handshake at k=PAYLOAD_FLITS goes to FOOTER.
- FOOTER: `footer_valid=1`. On handshake: `seq[o_vc]++`, `o_pkt_total++`, `last_vc<=o_vc`. Go to GAP if `i_gap!=0`, else IDLE.
- GAP: count down `i_gap` (value latched at footer handshake), then go to IDLE.
- Data patterns (seq is the per-channel 16-bit counter; vc is zero-extended to 8 bits):
  - header = {8'hE0, vc, seq, 96'h0}
  - payload k = {8'hD0, vc, seq, 8'(k), 88'h0}
  - footer = {8'hF0, vc, seq, 8'(PAYLOAD_FLITS+1), 88'h0}
- At most one of the three valids is high in any cycle.
- Once a valid rises, it and `data` stay stable until the matching ready is seen.
- `i_enable` deasserted mid-packet: the packet completes and no new header starts.
- `i_vc_mask` is sampled only in IDLE. Changes mid-packet do not affect the packet in flight.
- Mask zero, or enable low: remain in IDLE with all valids low.
- seq wraps 16'hFFFF→0 per channel. Channels are independent.
- `resetn` low mid-packet: immediate abort. No resumption; the next packet after reset is a fresh header.

## Timing
- Reset values:
  - all valids 0, `data` 0, `o_vc` 0, `o_busy` 0, `o_pkt_total` 0
  - all seq 0, `last_vc` N-1, so channel 0 is served first when eligible
  - state IDLE
- Latency: enable and nonzero mask sampled in IDLE → `header_valid` high the next cycle.
- Handshakes are registered. With all readies held high, a packet takes exactly PAYLOAD_FLITS+2 consecutive cycles.
- Back-to-back packets (`i_gap=0`): footer handshake at cycle t, IDLE at t+1, next header at t+2.
- `i_gap=G>0`: next header at t+G+2.
- `o_vc` is updated on the IDLE→HEADER transition and is stable until the next selection.

## Structure
- Shared package `exanet_pkg`: flit tag constants (`EXA_TAG_HDR=8'hE0`, `EXA_TAG_PLD=8'hD0`, `EXA_TAG_FTR=8'hF0`) and a state enum typedef. These are reused by pattern-checking consumers.
- Sub-module `exa_rr_vc_arbiter` (params N). Inputs: mask, last index. Outputs: grant index, grant_valid. Purely combinational.

## Test plan
- Reset release, mask=4'b0001, enable=1, readies always 1, gap=0 → header `E0_00_0000_…` one cycle after enable. Payloads k=1..16, then footer tag F0 with k=17. 18 flits in 18 cycles. Next header has seq=1 at t+2.
- Mask=4'b1111, 8 packets → `o_vc` sequence 0,1,2,3,0,1,2,3. After the run, each channel's seq=2 and `o_pkt_total=8`.
- Random backpressure (ready low ~50%) → valid and data never change while ready is low. Flit count per packet is still 18, and at most one valid is high in any cycle.
- Enable dropped during payload k=5 → packet finishes through footer, then IDLE holds with all valids 0.
- `i_gap=3` → exactly 3 GAP cycles plus 1 IDLE cycle between footer handshake and next `header_valid`.
- Assert `resetn` low during PAYLOAD → valids 0 immediately. After release the first flit is a header with seq=0 on channel 0.
